// File: rtl/fmps_pkg.sv
// FMPS readout shared definitions: word field positions, default slot index width, scanner FSM encodings.
// Port summary: none (package only).
// Imported by the readout scanner and the per-word checker.
package fmps_pkg;

    localparam int FMPS_DEFAULT_INDEX_WIDTH = 5;

    // FMPS word layout
    localparam int FMPS_BIT_FMPS2CC = 31;
    localparam int FMPS_BIT_CC2CC   = 30;
    localparam int FMPS_BIT_RSVD    = 29;
    localparam int FMPS_IDX_MSB     = 28;
    localparam int FMPS_IDX_LSB     = 24;
    localparam int FMPS_DATA_MSB    = 23;
    localparam int FMPS_DATA_LSB    = 8;
    localparam int FMPS_CYC_MSB     = 7;
    localparam int FMPS_CYC_LSB     = 0;
    localparam int FMPS_IDX_W       = FMPS_IDX_MSB - FMPS_IDX_LSB + 1;
    localparam int FMPS_CYC_W       = FMPS_CYC_MSB - FMPS_CYC_LSB + 1;

    // Scanner FSM encodings
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

endpackage

// File: rtl/fmps_word_check.sv
// Purpose: combinational check of one FMPS readout word against the slot it was read from.
// Ports: word (32b DPRAM word), slot (expected index) -> trip (FMPS2CC|CC2CC), index_err
//        (index field != slot or reserved bit set), cycle (word cycle counter field).
module fmps_word_check
    import fmps_pkg::*;
#(
    parameter int INDEX_WIDTH = FMPS_DEFAULT_INDEX_WIDTH
) (
    input  logic [31:0]             word,
    input  logic [INDEX_WIDTH-1:0]  slot,
    output logic                    trip,
    output logic                    index_err,
    output logic [FMPS_CYC_W-1:0]   cycle
);

    logic [FMPS_IDX_W-1:0] slot_ext;
    // Payload bits are not inspected here; reduce them so they are visibly consumed.
    logic                  unused_data;

    always_comb begin
        slot_ext    = FMPS_IDX_W'(slot);
        trip        = word[FMPS_BIT_FMPS2CC] | word[FMPS_BIT_CC2CC];
        index_err   = (word[FMPS_IDX_MSB:FMPS_IDX_LSB] != slot_ext) | word[FMPS_BIT_RSVD];
        cycle       = word[FMPS_CYC_MSB:FMPS_CYC_LSB];
        unused_data = ^word[FMPS_DATA_MSB:FMPS_DATA_LSB];
    end

endmodule

// File: rtl/fmps_readout_scanner.sv
// Purpose: on each FA-cycle strobe, scan every FMPS slot of the read-link DPRAM and publish
//          trip / missing / index-error bitmaps, the common cycle counter and a sysTrip summary.
// Ports: sysClk/sysReset, sysCycleStrobe + fmpsBitmap/sysEnableBitmap in; readoutAddress out,
//        readoutFMPS in; sysScanBusy/sysScanDone and the result registers out. Fixed latency
//        2**IW*(READ_LATENCY+1)+1 from strobe edge to done; strobes while scanning are counted.
module fmps_readout_scanner
    import fmps_pkg::*;
#(
    parameter int    INDEX_WIDTH         = FMPS_DEFAULT_INDEX_WIDTH,
    parameter int    READ_LATENCY        = 1,
    parameter string CHECK_CYCLE_COUNTER = "true"
) (
    input  logic                        sysClk,
    input  logic                        sysReset,
    input  logic                        sysCycleStrobe,
    input  logic [2**INDEX_WIDTH-1:0]   fmpsBitmap,
    input  logic [2**INDEX_WIDTH-1:0]   sysEnableBitmap,
    output logic [INDEX_WIDTH-1:0]      readoutAddress,
    input  logic [31:0]                 readoutFMPS,
    output logic                        sysScanBusy,
    output logic                        sysScanDone,
    output logic [2**INDEX_WIDTH-1:0]   sysTripBitmap,
    output logic [2**INDEX_WIDTH-1:0]   sysMissingBitmap,
    output logic [2**INDEX_WIDTH-1:0]   sysIndexErrBitmap,
    output logic [7:0]                  sysCycleCounter,
    output logic                        sysCycleMismatch,
    output logic                        sysTrip,
    output logic [15:0]                 sysOverrunCount
);

    localparam int NSLOT = 2**INDEX_WIDTH;
    // Hold counter covers the READ_LATENCY cycles spent in HOLD; SAMPLE is the final hold cycle.
    localparam int HCW   = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY);
    localparam logic [HCW-1:0]         HOLD_LAST = HCW'(READ_LATENCY - 1);
    localparam logic [HCW-1:0]         HOLD_ONE  = HCW'(1);
    localparam logic [INDEX_WIDTH-1:0] ADDR_LAST = INDEX_WIDTH'(NSLOT - 1);
    localparam logic [INDEX_WIDTH-1:0] ADDR_ONE  = INDEX_WIDTH'(1);
    localparam bit                     CHECK_CC  = (CHECK_CYCLE_COUNTER == "true");

    // Control
    logic [1:0]             state_q,   state_d;
    logic [HCW-1:0]         hold_q,    hold_d;
    logic [INDEX_WIDTH-1:0] addr_q,    addr_d;
    logic [NSLOT-1:0]       checked_q, checked_d;

    // Shadow accumulators for the scan in flight
    logic [NSLOT-1:0]       trip_sh_q, trip_sh_d;
    logic [NSLOT-1:0]       miss_sh_q, miss_sh_d;
    logic [NSLOT-1:0]       idx_sh_q,  idx_sh_d;
    logic [7:0]             ref_q,     ref_d;
    logic                   ref_vld_q, ref_vld_d;
    logic                   mism_sh_q, mism_sh_d;

    // Published results
    logic [NSLOT-1:0]       trip_q,    trip_d;
    logic [NSLOT-1:0]       miss_q,    miss_d;
    logic [NSLOT-1:0]       idx_q,     idx_d;
    logic [7:0]             cc_q,      cc_d;
    logic                   mism_q,    mism_d;
    logic                   strip_q,   strip_d;
    logic                   done_q,    done_d;
    logic [15:0]            ovr_q,     ovr_d;

    logic                   chk_trip;
    logic                   chk_idx_err;
    logic [7:0]             chk_cycle;

    fmps_word_check #(
        .INDEX_WIDTH (INDEX_WIDTH)
    ) u_word_check (
        .word      (readoutFMPS),
        .slot      (addr_q),
        .trip      (chk_trip),
        .index_err (chk_idx_err),
        .cycle     (chk_cycle)
    );

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        addr_d    = addr_q;
        checked_d = checked_q;
        trip_sh_d = trip_sh_q;
        miss_sh_d = miss_sh_q;
        idx_sh_d  = idx_sh_q;
        ref_d     = ref_q;
        ref_vld_d = ref_vld_q;
        mism_sh_d = mism_sh_q;
        trip_d    = trip_q;
        miss_d    = miss_q;
        idx_d     = idx_q;
        cc_d      = cc_q;
        mism_d    = mism_q;
        strip_d   = strip_q;
        done_d    = 1'b0;
        ovr_d     = ovr_q;

        case (state_q)
            ST_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            ST_SAMPLE: begin
                if (checked_q[addr_q]) begin
                    trip_sh_d[addr_q] = chk_trip;
                    idx_sh_d[addr_q]  = chk_idx_err;
                    // First checked slot defines the reference; later ones are compared to it.
                    if (!ref_vld_q) begin
                        ref_d     = chk_cycle;
                        ref_vld_d = 1'b1;
                    end else if (CHECK_CC && (chk_cycle != ref_q)) begin
                        mism_sh_d = 1'b1;
                    end
                end
                hold_d  = '0;
                addr_d  = addr_q + ADDR_ONE;
                state_d = (addr_q == ADDR_LAST) ? ST_DONE : ST_HOLD;
            end
            ST_DONE: begin
                trip_d  = trip_sh_q;
                miss_d  = miss_sh_q;
                idx_d   = idx_sh_q;
                cc_d    = ref_q;
                mism_d  = mism_sh_q;
                strip_d = (|trip_sh_q) | (|miss_sh_q) | (|idx_sh_q) | mism_sh_q;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: ;
        endcase

        // IDLE and DONE both accept a strobe; the DONE publish above reads only _q values,
        // so clearing the shadows here cannot corrupt the results being copied out.
        if (sysCycleStrobe && ((state_q == ST_IDLE) || (state_q == ST_DONE))) begin
            checked_d = fmpsBitmap & sysEnableBitmap;
            miss_sh_d = sysEnableBitmap & ~fmpsBitmap;
            trip_sh_d = '0;
            idx_sh_d  = '0;
            ref_d     = '0;
            ref_vld_d = 1'b0;
            mism_sh_d = 1'b0;
            addr_d    = '0;
            hold_d    = '0;
            state_d   = ST_HOLD;
        end

        if (sysCycleStrobe && ((state_q == ST_HOLD) || (state_q == ST_SAMPLE)) &&
            (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end
    end

    always_ff @(posedge sysClk) begin
        if (sysReset) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            addr_q    <= '0;
            checked_q <= '0;
            trip_sh_q <= '0;
            miss_sh_q <= '0;
            idx_sh_q  <= '0;
            ref_q     <= '0;
            ref_vld_q <= 1'b0;
            mism_sh_q <= 1'b0;
            trip_q    <= '0;
            miss_q    <= '0;
            idx_q     <= '0;
            cc_q      <= '0;
            mism_q    <= 1'b0;
            strip_q   <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            addr_q    <= addr_d;
            checked_q <= checked_d;
            trip_sh_q <= trip_sh_d;
            miss_sh_q <= miss_sh_d;
            idx_sh_q  <= idx_sh_d;
            ref_q     <= ref_d;
            ref_vld_q <= ref_vld_d;
            mism_sh_q <= mism_sh_d;
            trip_q    <= trip_d;
            miss_q    <= miss_d;
            idx_q     <= idx_d;
            cc_q      <= cc_d;
            mism_q    <= mism_d;
            strip_q   <= strip_d;
            done_q    <= done_d;
            ovr_q     <= ovr_d;
        end
    end

    assign readoutAddress    = addr_q;
    assign sysScanBusy       = (state_q != ST_IDLE);
    assign sysScanDone       = done_q;
    assign sysTripBitmap     = trip_q;
    assign sysMissingBitmap  = miss_q;
    assign sysIndexErrBitmap = idx_q;
    assign sysCycleCounter   = cc_q;
    assign sysCycleMismatch  = mism_q;
    assign sysTrip           = strip_q;
    assign sysOverrunCount   = ovr_q;

endmodule

// File: tb/tb_fmps_readout_scanner.sv
// Scoreboard bench for fmps_readout_scanner: expected scan results are queued at strobe time
// and popped by an independent monitor whenever sysScanDone is seen.
module tb_fmps_readout_scanner;

    localparam int IW  = 5;
    localparam int NS  = 32;
    localparam int RL  = 1;
    localparam int LAT = NS * (RL + 1) + 1;

    logic           sysClk = 1'b0;
    logic           sysReset;
    logic           sysCycleStrobe;
    logic [NS-1:0]  fmpsBitmap;
    logic [NS-1:0]  sysEnableBitmap;
    logic [IW-1:0]  readoutAddress;
    logic [31:0]    readoutFMPS;
    logic           sysScanBusy;
    logic           sysScanDone;
    logic [NS-1:0]  sysTripBitmap;
    logic [NS-1:0]  sysMissingBitmap;
    logic [NS-1:0]  sysIndexErrBitmap;
    logic [7:0]     sysCycleCounter;
    logic           sysCycleMismatch;
    logic           sysTrip;
    logic [15:0]    sysOverrunCount;

    fmps_readout_scanner #(
        .INDEX_WIDTH         (IW),
        .READ_LATENCY        (RL),
        .CHECK_CYCLE_COUNTER ("true")
    ) dut (
        .sysClk            (sysClk),
        .sysReset          (sysReset),
        .sysCycleStrobe    (sysCycleStrobe),
        .fmpsBitmap        (fmpsBitmap),
        .sysEnableBitmap   (sysEnableBitmap),
        .readoutAddress    (readoutAddress),
        .readoutFMPS       (readoutFMPS),
        .sysScanBusy       (sysScanBusy),
        .sysScanDone       (sysScanDone),
        .sysTripBitmap     (sysTripBitmap),
        .sysMissingBitmap  (sysMissingBitmap),
        .sysIndexErrBitmap (sysIndexErrBitmap),
        .sysCycleCounter   (sysCycleCounter),
        .sysCycleMismatch  (sysCycleMismatch),
        .sysTrip           (sysTrip),
        .sysOverrunCount   (sysOverrunCount)
    );

    always #5 sysClk = ~sysClk;

    // Behavioural DPRAM readout port, one cycle of latency
    logic [31:0] mem [NS];
    always @(posedge sysClk) readoutFMPS <= mem[readoutAddress];

    int cyc = 0;
    always @(posedge sysClk) cyc++;

    int checks = 0;
    int errors = 0;
    int exp_ovr = 0;

    typedef struct {
        logic [NS-1:0] trip;
        logic [NS-1:0] miss;
        logic [NS-1:0] idx;
        logic [7:0]    cc;
        logic          mism;
        logic          strip;
        int            done_cyc;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: per-slot rules evaluated over the stored words
    function automatic exp_t model(input logic [NS-1:0] en, input logic [NS-1:0] pres);
        exp_t       e;
        bit         have_ref;
        logic [7:0] r;
        logic [31:0] w;
        logic [4:0] sidx;
        e.trip = '0; e.miss = '0; e.idx = '0; e.mism = 1'b0; e.done_cyc = 0;
        have_ref = 0; r = 8'h00;
        for (int s = 0; s < NS; s++) begin
            sidx = 5'(s);
            if (en[s] && !pres[s]) e.miss[s] = 1'b1;
            if (en[s] && pres[s]) begin
                w = mem[s];
                if (w[31] || w[30]) e.trip[s] = 1'b1;
                if ((w[28:24] != sidx) || w[29]) e.idx[s] = 1'b1;
                if (!have_ref) begin
                    r = w[7:0];
                    have_ref = 1;
                end else if (w[7:0] != r) begin
                    e.mism = 1'b1;
                end
            end
        end
        e.cc = r;
        e.strip = (|e.trip) || (|e.miss) || (|e.idx) || e.mism;
        return e;
    endfunction

    // Monitor
    always @(posedge sysClk) begin
        #1;
        if (!sysReset && sysScanDone) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: done at cycle %0d with nothing pending", cyc);
            end else begin
                mon_e = sb_q.pop_front();
                chk("done_latency", 64'(cyc), 64'(mon_e.done_cyc));
                chk("trip_bitmap", 64'(sysTripBitmap), 64'(mon_e.trip));
                chk("missing_bitmap", 64'(sysMissingBitmap), 64'(mon_e.miss));
                chk("indexerr_bitmap", 64'(sysIndexErrBitmap), 64'(mon_e.idx));
                chk("cycle_counter", 64'(sysCycleCounter), 64'(mon_e.cc));
                chk("cycle_mismatch", 64'(sysCycleMismatch), 64'(mon_e.mism));
                chk("sys_trip", 64'(sysTrip), 64'(mon_e.strip));
            end
        end
    end

    task automatic tick();
        @(posedge sysClk);
        #1;
    endtask

    task automatic fill_clean(input logic [7:0] cycv);
        for (int s = 0; s < NS; s++) begin
            mem[s] = {3'b000, 5'(s), 16'($urandom), cycv};
        end
    endtask

    // Entered and left at posedge+1
    task automatic issue_strobe(input logic [NS-1:0] en, input logic [NS-1:0] pres);
        exp_t e;
        sysEnableBitmap = en;
        fmpsBitmap      = pres;
        sysCycleStrobe  = 1'b1;
        e = model(en, pres);
        e.done_cyc = cyc + 1 + LAT;
        sb_q.push_back(e);
        tick();
        sysCycleStrobe = 1'b0;
    endtask

    task automatic drain(input string nm);
        int i;
        for (i = 0; i < 400; i++) begin
            if (sb_q.size() == 0 && !sysScanBusy) break;
            tick();
        end
        if (i == 400) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d results still pending, required 0", nm, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic scan(input string nm, input logic [NS-1:0] en, input logic [NS-1:0] pres);
        issue_strobe(en, pres);
        drain(nm);
    endtask

    initial begin
        logic [NS-1:0] en;
        logic [NS-1:0] pres;
        int            c0;

        sysReset = 1'b1;
        sysCycleStrobe = 1'b0;
        fmpsBitmap = '0;
        sysEnableBitmap = '0;
        fill_clean(8'h00);
        repeat (3) tick();

        chk("rst_busy", 64'(sysScanBusy), 64'd0);
        chk("rst_done", 64'(sysScanDone), 64'd0);
        chk("rst_addr", 64'(readoutAddress), 64'd0);
        chk("rst_trip", 64'(sysTrip), 64'd0);
        chk("rst_trip_bitmap", 64'(sysTripBitmap), 64'd0);
        chk("rst_cc", 64'(sysCycleCounter), 64'd0);
        chk("rst_overrun", 64'(sysOverrunCount), 64'd0);
        sysReset = 1'b0;
        tick();

        // Clean scan of 12 slots, with a busy check partway through
        fill_clean(8'h05);
        issue_strobe(32'h0000_0FFF, 32'h0000_0FFF);
        repeat (5) tick();
        chk("busy_mid_scan", 64'(sysScanBusy), 64'd1);
        drain("clean");

        // Trip in slot 3, then slot 3 disabled
        mem[3][31] = 1'b1;
        scan("trip", 32'h0000_0FFF, 32'h0000_0FFF);
        scan("trip_disabled", 32'h0000_0FF7, 32'h0000_0FFF);
        fill_clean(8'h05);

        // Missing slot 3
        scan("missing", 32'h0000_0FFF, 32'h0000_0FF7);

        // Index error in slot 7, cycle mismatch in slot 9
        mem[7][28:24] = 5'd6;
        mem[9][7:0] = 8'h06;
        scan("idx_mism", 32'h0000_0FFF, 32'h0000_0FFF);
        fill_clean(8'h05);

        // Zero checked slots
        scan("none_checked", 32'h0000_0000, 32'hFFFF_FFFF);

        // Overrun: second strobe 10 cycles into a scan is dropped
        issue_strobe(32'h0000_0FFF, 32'h0000_0FFF);
        repeat (9) tick();
        sysCycleStrobe = 1'b1;
        exp_ovr++;
        tick();
        sysCycleStrobe = 1'b0;
        drain("overrun");
        chk("overrun_count", 64'(sysOverrunCount), 64'(exp_ovr));

        // Strobe in the DONE cycle chains straight into a new scan
        c0 = cyc;
        issue_strobe(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        while (cyc < c0 + 65) tick();
        chk("busy_in_done", 64'(sysScanBusy), 64'd1);
        mem[12][30] = 1'b1;
        issue_strobe(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain("back_to_back");
        chk("overrun_after_b2b", 64'(sysOverrunCount), 64'(exp_ovr));
        fill_clean(8'h05);

        // Randomized scans
        for (int n = 0; n < 25; n++) begin
            for (int s = 0; s < NS; s++) begin
                mem[s] = {($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'(s),
                          16'($urandom),
                          ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(n)};
            end
            en = $urandom();
            pres = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : 32'($urandom());
            scan("random", en, pres);
        end

        // Reset 30 cycles into a scan aborts it
        issue_strobe(32'h0000_0FFF, 32'h0000_0FF7);
        repeat (29) tick();
        sysReset = 1'b1;
        tick();
        sysReset = 1'b0;
        sb_q.delete();
        exp_ovr = 0;
        chk("abort_busy", 64'(sysScanBusy), 64'd0);
        chk("abort_missing", 64'(sysMissingBitmap), 64'd0);
        chk("abort_trip", 64'(sysTrip), 64'd0);
        chk("abort_overrun", 64'(sysOverrunCount), 64'(exp_ovr));
        repeat (80) tick();
        fill_clean(8'h2A);
        scan("after_abort", 32'h0000_FFFF, 32'h0000_FFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
